mc_ctrl_fsm_hs: RTL

Main control FSM for the multicycle RV32I core. It is the parametrised successor to the fixed-latency control FSM.
- Memory access supports either a ready handshake or a configurable fixed latency.
- Adds LUI, AUIPC, the full branch set and an optional multicycle mul/div path.
- Flags illegal opcodes.
- Drives the datapath muxes and enables. ALU function decode stays in aludecoder, driven by ALUop.

---
 rtl/mc_ctrl_fsm_hs_if.sv | 40 ++++
 rtl/mc_ctrl_fsm_hs.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm_hs_if.sv
// Control bundle between the multicycle control FSM and the RV32I datapath.
// The FSM uses the master modport; the datapath side uses slave.
interface mc_ctrl_fsm_hs_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b0;
  logic       Zero;
  logic       ALUb31;
  logic       Cout;
  logic       mem_ready;
  logic       md_done;

  logic       PCWrite;
  logic       AddrSrc;
  logic       MemRead;
  logic       MemWrite;
  logic [2:0] MemOp;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ALUop;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       JALR_LSB;
  logic       md_start;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b0, Zero, ALUb31, Cout, mem_ready, md_done,
    output PCWrite, AddrSrc, MemRead, MemWrite, MemOp, IRWrite, RegWrite,
           ALUop, ALUSrcA, ALUSrcB, ResultSrc, JALR_LSB, md_start, illegal, state
  );

  modport slave (
    output op, funct3, funct7b0, Zero, ALUb31, Cout, mem_ready, md_done,
    input  PCWrite, AddrSrc, MemRead, MemWrite, MemOp, IRWrite, RegWrite,
           ALUop, ALUSrcA, ALUSrcB, ResultSrc, JALR_LSB, md_start, illegal, state
  );
endinterface

// File: rtl/mc_ctrl_fsm_hs.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute,
// waits on memory by handshake or fixed latency, and dispatches mul/div.
module mc_ctrl_fsm_hs #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MEM_LAT       = 1,
  parameter bit          EN_MULDIV     = 1'b0
) (
  input logic              clk,
  input logic              rst,
  mc_ctrl_fsm_hs_if.master bus
);

  // R/I execute and LUI/AUIPC each share one state and pick operands from op[5],
  // which keeps all sixteen states inside the 4-bit debug encoding.
  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExec, StAluWb,
    StJal, StJalr, StLink, StBranch, StUimm, StMulDiv, StMdWait, StIllegal
  } state_e;

  localparam logic [3:0] LastWait = 4'(MEM_LAT - 1);

  state_e     state_q, state_d, dec_next;
  logic [3:0] wcnt_q, wcnt_d;
  logic       mem_ok;
  logic       br_taken, br_bad;

  logic       pc_write, addr_src, mem_read, mem_write, ir_write, reg_write;
  logic       jalr_lsb, md_start, illegal;
  logic [2:0] mem_op;
  logic [1:0] alu_op, src_a, src_b, result_src;

  assign mem_ok = MEM_HANDSHAKE ? bus.mem_ready : (wcnt_q == LastWait);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    if (state_d != state_q) begin
      wcnt_d = 4'd0;
    end else if (wcnt_q != 4'hf) begin
      wcnt_d = wcnt_q + 4'd1;
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (bus.funct3)
      3'b000:  br_taken = bus.Zero;
      3'b001:  br_taken = !bus.Zero;
      3'b100:  br_taken = bus.ALUb31;
      3'b101:  br_taken = !bus.ALUb31;
      3'b110:  br_taken = !bus.Cout;
      3'b111:  br_taken = bus.Cout;
      default: br_bad   = 1'b1;
    endcase
  end

  always_comb begin
    dec_next = StIllegal;
    case (bus.op)
      7'b0000011, 7'b0100011: dec_next = StMemAdr;
      7'b0110011: begin
        if (bus.funct7b0) begin
          dec_next = EN_MULDIV ? StMulDiv : StIllegal;
        end else begin
          dec_next = StExec;
        end
      end
      7'b0010011:             dec_next = StExec;
      7'b1101111:             dec_next = StJal;
      7'b1100111:             dec_next = StJalr;
      7'b1100011:             dec_next = StBranch;
      7'b0110111, 7'b0010111: dec_next = StUimm;
      default:                dec_next = StIllegal;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    addr_src   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_op     = 3'b010;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    result_src = 2'b00;
    jalr_lsb   = 1'b0;
    md_start   = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_read   = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        if (mem_ok) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        src_a   = 2'b01;
        src_b   = 2'b01;
        state_d = dec_next;
      end
      StMemAdr: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = bus.op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        addr_src = 1'b1;
        mem_read = 1'b1;
        mem_op   = bus.funct3;
        if (mem_ok) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        addr_src  = 1'b1;
        mem_write = 1'b1;
        mem_op    = bus.funct3;
        if (mem_ok) state_d = StFetch;
      end
      StExec: begin
        src_a   = 2'b10;
        src_b   = bus.op[5] ? 2'b00 : 2'b01;
        alu_op  = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StJal: begin
        pc_write = 1'b1;
        src_a    = 2'b01;
        src_b    = 2'b10;
        state_d  = StAluWb;
      end
      StJalr: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        result_src = 2'b10;
        jalr_lsb   = 1'b1;
        pc_write   = 1'b1;
        state_d    = StLink;
      end
      StLink: begin
        src_a      = 2'b01;
        src_b      = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        src_a    = 2'b10;
        alu_op   = 2'b01;
        pc_write = br_taken & ~br_bad;
        illegal  = br_bad;
        state_d  = StFetch;
      end
      StUimm: begin
        src_a   = bus.op[5] ? 2'b11 : 2'b01;
        src_b   = 2'b01;
        state_d = StAluWb;
      end
      StMulDiv: begin
        md_start = 1'b1;
        state_d  = StMdWait;
      end
      StMdWait: begin
        if (bus.md_done) begin
          result_src = 2'b11;
          reg_write  = 1'b1;
          state_d    = StFetch;
        end
      end
      StIllegal: begin
        illegal = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Write and pulse strobes are masked by rst so nothing fires while reset is held.
  assign bus.PCWrite   = pc_write & ~rst;
  assign bus.MemRead   = mem_read & ~rst;
  assign bus.MemWrite  = mem_write & ~rst;
  assign bus.IRWrite   = ir_write & ~rst;
  assign bus.RegWrite  = reg_write & ~rst;
  assign bus.md_start  = md_start & ~rst;
  assign bus.illegal   = illegal & ~rst;
  assign bus.AddrSrc   = addr_src;
  assign bus.MemOp     = mem_op;
  assign bus.ALUop     = alu_op;
  assign bus.ALUSrcA   = src_a;
  assign bus.ALUSrcB   = src_b;
  assign bus.ResultSrc = result_src;
  assign bus.JALR_LSB  = jalr_lsb;
  assign bus.state     = state_q;

endmodule
